// File: rtl/ddr2_pkg.sv
// ddr2_pkg: definitions shared by the DDR2 write-data path.
//   BURST_LEN      beats per write burst (BL8)
//   BURST_CYC      clock cycles per burst (two beats per cycle)
//   DDR2_DQ_W/DM_W default data and byte-mask widths per beat
//   wtx_state_t    state encoding of the write transmitter FSM
package ddr2_pkg;

    localparam int BURST_LEN = 8;
    localparam int BURST_CYC = BURST_LEN / 2;
    localparam int DDR2_DQ_W = 16;
    localparam int DDR2_DM_W = DDR2_DQ_W / 8;

    typedef enum logic [2:0] {
        WTX_IDLE,
        WTX_WAIT,
        WTX_PRE,
        WTX_BURST,
        WTX_POST
    } wtx_state_t;

endpackage

// File: rtl/ddr2_wbuf8.sv
// ddr2_wbuf8: 8-entry write buffer holding one BL8 burst (data + byte masks).
//   clk, reset_n  clock and asynchronous active-low reset (clears all entries)
//   wr_en/wr_ptr  write entry wr_ptr with {din, dmin} at posedge
//   din, dmin     data and byte mask for the addressed entry
//   snap          parallel view of all entries, entry i at snap[i] as {dq, dm};
//                 an entry being written this cycle shows the new value so a
//                 snapshot taken on the same edge includes the write
module ddr2_wbuf8
    import ddr2_pkg::*;
#(
    parameter int DQ_W = DDR2_DQ_W,
    parameter int DM_W = DDR2_DM_W
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  wr_en,
    input  logic [2:0]                            wr_ptr,
    input  logic [DQ_W-1:0]                       din,
    input  logic [DM_W-1:0]                       dmin,
    output logic [BURST_LEN-1:0][DQ_W+DM_W-1:0]   snap
);

    localparam int EW = DQ_W + DM_W;

    logic [EW-1:0] mem_reg [BURST_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_entry
            logic hit;
            assign hit = wr_en && (wr_ptr == 3'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_reg[gi] <= '0;
                end else if (hit) begin
                    mem_reg[gi] <= {din, dmin};
                end
            end

            // Write-through so a talk on the writing edge sees the new entry.
            assign snap[gi] = hit ? {din, dmin} : mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/ddr2_wdata_tx8.sv
// ddr2_wdata_tx8: DDR2 write-data transmitter for one BL8 burst.
// The controller fills the write buffer and pulses talk; WLAT cycles later the
// block drives a DQS preamble, four cycles of rise/fall data pairs with DQS
// toggling, and a postamble, all as registered per-cycle pairs for DDR pads.
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en, wr_ptr,
//   din, dmin             write port of the 8-entry buffer (accepted any time)
//   talk                  burst start pulse (honoured only in IDLE)
//   busy                  high from cycle 1 through the postamble cycle
//   done                  pulse in the postamble cycle
//   talk_err              pulse one cycle after a talk that was ignored
//   dq_rise/dq_fall,
//   dm_rise/dm_fall       data/mask for the two half-cycles (hold when idle)
//   dq_oe                 DQ/DM output enable (burst cycles only)
//   dqs_rise/dqs_fall     DQS levels for the two half-cycles
//   dqs_oe                DQS output enable (preamble through postamble)
module ddr2_wdata_tx8
    import ddr2_pkg::*;
#(
    parameter int DQ_W = DDR2_DQ_W,
    parameter int DM_W = DDR2_DM_W,
    parameter int WLAT = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [2:0]      wr_ptr,
    input  logic [DQ_W-1:0] din,
    input  logic [DM_W-1:0] dmin,
    input  logic            talk,
    output logic            busy,
    output logic            done,
    output logic            talk_err,
    output logic [DQ_W-1:0] dq_rise,
    output logic [DQ_W-1:0] dq_fall,
    output logic [DM_W-1:0] dm_rise,
    output logic [DM_W-1:0] dm_fall,
    output logic            dq_oe,
    output logic            dqs_rise,
    output logic            dqs_fall,
    output logic            dqs_oe
);

    localparam int EW = DQ_W + DM_W;

    logic [BURST_LEN-1:0][EW-1:0] snap;
    logic [BURST_LEN-1:0][EW-1:0] shift_reg, shift_next;

    wtx_state_t state_reg, state_next;
    logic [3:0] lat_reg, lat_next;
    logic [1:0] beat_reg, beat_next;

    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            talk_err_reg, talk_err_next;
    logic [DQ_W-1:0] dq_rise_reg, dq_rise_next;
    logic [DQ_W-1:0] dq_fall_reg, dq_fall_next;
    logic [DM_W-1:0] dm_rise_reg, dm_rise_next;
    logic [DM_W-1:0] dm_fall_reg, dm_fall_next;
    logic            dq_oe_reg, dq_oe_next;
    logic            dqs_rise_reg, dqs_rise_next;
    logic            dqs_fall_reg, dqs_fall_next;
    logic            dqs_oe_reg, dqs_oe_next;

    ddr2_wbuf8 #(
        .DQ_W (DQ_W),
        .DM_W (DM_W)
    ) u_wbuf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .din     (din),
        .dmin    (dmin),
        .snap    (snap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= WTX_IDLE;
            lat_reg      <= '0;
            beat_reg     <= '0;
            shift_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            talk_err_reg <= 1'b0;
            dq_rise_reg  <= '0;
            dq_fall_reg  <= '0;
            dm_rise_reg  <= '0;
            dm_fall_reg  <= '0;
            dq_oe_reg    <= 1'b0;
            dqs_rise_reg <= 1'b0;
            dqs_fall_reg <= 1'b0;
            dqs_oe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lat_reg      <= lat_next;
            beat_reg     <= beat_next;
            shift_reg    <= shift_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            talk_err_reg <= talk_err_next;
            dq_rise_reg  <= dq_rise_next;
            dq_fall_reg  <= dq_fall_next;
            dm_rise_reg  <= dm_rise_next;
            dm_fall_reg  <= dm_fall_next;
            dq_oe_reg    <= dq_oe_next;
            dqs_rise_reg <= dqs_rise_next;
            dqs_fall_reg <= dqs_fall_next;
            dqs_oe_reg   <= dqs_oe_next;
        end
    end

    // Next-state and next-output logic. Outputs are derived from state_next so
    // that the registered outputs line up with the state occupying each cycle.
    always_comb begin
        state_next    = state_reg;
        lat_next      = lat_reg;
        beat_next     = beat_reg;
        shift_next    = shift_reg;
        talk_err_next = talk && (state_reg != WTX_IDLE);

        case (state_reg)
            WTX_IDLE: begin
                if (talk) begin
                    shift_next = snap;
                    lat_next   = 4'd1;
                    state_next = (WLAT == 1) ? WTX_PRE : WTX_WAIT;
                end
            end
            WTX_WAIT: begin
                // lat_reg is the number of the WAIT cycle currently running.
                if (lat_reg == 4'(WLAT - 1)) begin
                    state_next = WTX_PRE;
                end else begin
                    lat_next = lat_reg + 4'd1;
                end
            end
            WTX_PRE: begin
                state_next = WTX_BURST;
                beat_next  = 2'd0;
            end
            WTX_BURST: begin
                if (beat_reg == 2'(BURST_CYC - 1)) begin
                    state_next = WTX_POST;
                end else begin
                    beat_next = beat_reg + 2'd1;
                end
            end
            WTX_POST: begin
                state_next = WTX_IDLE;
                beat_next  = 2'd0;
            end
            default: begin
                state_next = WTX_IDLE;
            end
        endcase

        busy_next     = (state_next != WTX_IDLE);
        done_next     = (state_next == WTX_POST);
        dq_oe_next    = (state_next == WTX_BURST);
        dqs_oe_next   = (state_next == WTX_PRE) || (state_next == WTX_BURST) ||
                        (state_next == WTX_POST);
        dqs_rise_next = (state_next == WTX_BURST);
        dqs_fall_next = 1'b0;

        // Data holds its last beat outside the burst.
        dq_rise_next = dq_rise_reg;
        dq_fall_next = dq_fall_reg;
        dm_rise_next = dm_rise_reg;
        dm_fall_next = dm_fall_reg;

        // Each burst cycle consumes the two lowest entries (beats 2k, 2k+1).
        if (state_next == WTX_BURST) begin
            {dq_rise_next, dm_rise_next} = shift_reg[0];
            {dq_fall_next, dm_fall_next} = shift_reg[1];
            shift_next = shift_reg >> (2 * EW);
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign talk_err = talk_err_reg;
    assign dq_rise  = dq_rise_reg;
    assign dq_fall  = dq_fall_reg;
    assign dm_rise  = dm_rise_reg;
    assign dm_fall  = dm_fall_reg;
    assign dq_oe    = dq_oe_reg;
    assign dqs_rise = dqs_rise_reg;
    assign dqs_fall = dqs_fall_reg;
    assign dqs_oe   = dqs_oe_reg;

endmodule

// File: tb/tb_ddr2_wdata_tx8.sv
// tb_ddr2_wdata_tx8: scoreboard bench for ddr2_wdata_tx8 with two instances,
// WLAT=2 (u_dut2) and WLAT=1 (u_dut1), sharing clock, reset and write port.
module tb_ddr2_wdata_tx8;

    localparam int DQ_W = 16;
    localparam int DM_W = 2;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            talk_err;
        logic            dq_oe;
        logic            dqs_oe;
        logic            dqs_rise;
        logic            dqs_fall;
        logic [DQ_W-1:0] dq_rise;
        logic [DQ_W-1:0] dq_fall;
        logic [DM_W-1:0] dm_rise;
        logic [DM_W-1:0] dm_fall;
    } obs_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_ptr = '0;
    logic [DQ_W-1:0] din = '0;
    logic [DM_W-1:0] dmin = '0;
    logic            talk2 = 1'b0;
    logic            talk1 = 1'b0;

    logic a_busy, a_done, a_talk_err, a_dq_oe, a_dqs_rise, a_dqs_fall, a_dqs_oe;
    logic b_busy, b_done, b_talk_err, b_dq_oe, b_dqs_rise, b_dqs_fall, b_dqs_oe;
    logic [DQ_W-1:0] a_dq_rise, a_dq_fall, b_dq_rise, b_dq_fall;
    logic [DM_W-1:0] a_dm_rise, a_dm_fall, b_dm_rise, b_dm_fall;

    obs_t a_obs, b_obs;
    assign a_obs = {a_busy, a_done, a_talk_err, a_dq_oe, a_dqs_oe, a_dqs_rise,
                    a_dqs_fall, a_dq_rise, a_dq_fall, a_dm_rise, a_dm_fall};
    assign b_obs = {b_busy, b_done, b_talk_err, b_dq_oe, b_dqs_oe, b_dqs_rise,
                    b_dqs_fall, b_dq_rise, b_dq_fall, b_dm_rise, b_dm_fall};

    ddr2_wdata_tx8 #(.DQ_W(DQ_W), .DM_W(DM_W), .WLAT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .din(din), .dmin(dmin), .talk(talk2),
        .busy(a_busy), .done(a_done), .talk_err(a_talk_err),
        .dq_rise(a_dq_rise), .dq_fall(a_dq_fall),
        .dm_rise(a_dm_rise), .dm_fall(a_dm_fall), .dq_oe(a_dq_oe),
        .dqs_rise(a_dqs_rise), .dqs_fall(a_dqs_fall), .dqs_oe(a_dqs_oe)
    );

    ddr2_wdata_tx8 #(.DQ_W(DQ_W), .DM_W(DM_W), .WLAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .din(din), .dmin(dmin), .talk(talk1),
        .busy(b_busy), .done(b_done), .talk_err(b_talk_err),
        .dq_rise(b_dq_rise), .dq_fall(b_dq_fall),
        .dm_rise(b_dm_rise), .dm_fall(b_dm_fall), .dq_oe(b_dq_oe),
        .dqs_rise(b_dqs_rise), .dqs_fall(b_dqs_fall), .dqs_oe(b_dqs_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    obs_t exp_q[$];

    // Bench-side model of the write buffer and of the held data outputs.
    logic [DQ_W-1:0] m_dq [8];
    logic [DM_W-1:0] m_dm [8];
    logic [DQ_W-1:0] last_rise [3];
    logic [DQ_W-1:0] last_fall [3];
    logic [DM_W-1:0] last_mr [3];
    logic [DM_W-1:0] last_mf [3];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        check_val({tag, ".busy"},     32'(got.busy),     32'(exp.busy));
        check_val({tag, ".done"},     32'(got.done),     32'(exp.done));
        check_val({tag, ".talk_err"}, 32'(got.talk_err), 32'(exp.talk_err));
        check_val({tag, ".dq_oe"},    32'(got.dq_oe),    32'(exp.dq_oe));
        check_val({tag, ".dqs_oe"},   32'(got.dqs_oe),   32'(exp.dqs_oe));
        check_val({tag, ".dqs_rise"}, 32'(got.dqs_rise), 32'(exp.dqs_rise));
        check_val({tag, ".dqs_fall"}, 32'(got.dqs_fall), 32'(exp.dqs_fall));
        check_val({tag, ".dq_rise"},  32'(got.dq_rise),  32'(exp.dq_rise));
        check_val({tag, ".dq_fall"},  32'(got.dq_fall),  32'(exp.dq_fall));
        check_val({tag, ".dm_rise"},  32'(got.dm_rise),  32'(exp.dm_rise));
        check_val({tag, ".dm_fall"},  32'(got.dm_fall),  32'(exp.dm_fall));
    endtask

    function automatic obs_t sample(input int wl);
        return (wl == 1) ? b_obs : a_obs;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_dq[i] = '0;
            m_dm[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            last_rise[i] = '0;
            last_fall[i] = '0;
            last_mr[i]   = '0;
            last_mf[i]   = '0;
        end
    endtask

    // Called at #1 after an edge; occupies one cycle.
    task automatic bwrite(input int ptr, input logic [DQ_W-1:0] d,
                          input logic [DM_W-1:0] m);
        wr_en  = 1'b1;
        wr_ptr = 3'(ptr);
        din    = d;
        dmin   = m;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        m_dq[ptr] = d;
        m_dm[ptr] = m;
    endtask

    // Starts a burst on the instance with write latency wl from an idle cycle
    // (entered at #1 after an edge) and checks cycles 1..wl+6. Returns at #1
    // into cycle wl+6, which is idle, so a following call is back-to-back.
    //   wt_en/wt_d : write ptr 0 on the talk edge
    //   err_at     : drive a second talk in this cycle (0 = none)
    //   rw_at/rw_d : rewrite ptr 1 in this cycle (0 = none)
    //   abort_at   : pull reset_n in this cycle (0 = none)
    task automatic run_burst(input string name, input int wl,
                             input bit wt_en, input logic [DQ_W-1:0] wt_d,
                             input int err_at, input int rw_at,
                             input logic [DQ_W-1:0] rw_d, input int abort_at);
        logic [DQ_W-1:0] sd [8];
        logic [DM_W-1:0] sm [8];
        logic [DQ_W-1:0] lr, lf;
        logic [DM_W-1:0] lmr, lmf;
        obs_t e, got;
        int k;

        for (int i = 0; i < 8; i++) begin
            sd[i] = m_dq[i];
            sm[i] = m_dm[i];
        end
        if (wt_en) begin
            sd[0] = wt_d;
            sm[0] = '0;
        end
        lr = last_rise[wl];
        lf = last_fall[wl];
        lmr = last_mr[wl];
        lmf = last_mf[wl];

        for (int n = 1; n <= wl + 6; n++) begin
            e = '0;
            e.busy     = (n <= wl + 5);
            e.dqs_oe   = (n >= wl) && (n <= wl + 5);
            e.dq_oe    = (n >= wl + 1) && (n <= wl + 4);
            e.dqs_rise = e.dq_oe;
            e.done     = (n == wl + 5);
            e.talk_err = (err_at > 0) && (n == err_at + 1);
            if (e.dq_oe) begin
                k   = n - wl - 1;
                lr  = sd[2*k];
                lf  = sd[2*k+1];
                lmr = sm[2*k];
                lmf = sm[2*k+1];
            end
            e.dq_rise = lr;
            e.dq_fall = lf;
            e.dm_rise = lmr;
            e.dm_fall = lmf;
            exp_q.push_back(e);
        end
        last_rise[wl] = lr;
        last_fall[wl] = lf;
        last_mr[wl]   = lmr;
        last_mf[wl]   = lmf;

        if (wl == 1) talk1 = 1'b1;
        else         talk2 = 1'b1;
        if (wt_en) begin
            wr_en  = 1'b1;
            wr_ptr = 3'd0;
            din    = wt_d;
            dmin   = '0;
            m_dq[0] = wt_d;
            m_dm[0] = '0;
        end

        for (int n = 1; n <= wl + 6; n++) begin
            @(posedge clk);
            #1;
            talk1 = 1'b0;
            talk2 = 1'b0;
            wr_en = 1'b0;
            got = sample(wl);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s c%0d: scoreboard empty", name, n);
            end else begin
                e = exp_q.pop_front();
                check_obs($sformatf("%s c%0d", name, n), got, e);
            end
            $display("%s wlat=%0d cycle %0d: busy=%0b dqs_oe=%0b dq_oe=%0b rise=%h fall=%h",
                     name, wl, n, got.busy, got.dqs_oe, got.dq_oe,
                     got.dq_rise, got.dq_fall);
            if (n == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_obs($sformatf("%s async reset", name), sample(wl), '0);
                exp_q.delete();
                model_reset();
                #1;
                reset_n = 1'b1;
                return;
            end
            if (n == err_at) begin
                if (wl == 1) talk1 = 1'b1;
                else         talk2 = 1'b1;
            end
            if (n == rw_at) begin
                wr_en  = 1'b1;
                wr_ptr = 3'd1;
                din    = rw_d;
                dmin   = '0;
                m_dq[1] = rw_d;
                m_dm[1] = '0;
            end
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) begin
            bwrite(i, 16'h1000 + 16'(i), 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset wlat2", a_obs, '0);
        check_obs("reset wlat1", b_obs, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain burst
        load_ramp();
        run_burst("basic", 2, 1'b0, '0, 0, 0, '0, 0);

        // Byte mask on entry 3 only
        bwrite(3, 16'h1003, 2'b10);
        run_burst("mask", 2, 1'b0, '0, 0, 0, '0, 0);
        bwrite(3, 16'h1003, 2'b00);

        // Write-through on the talk edge, rewrite of ptr 1 after the snapshot
        run_burst("wthru", 2, 1'b1, 16'hBEEF, 0, 1, 16'h5555, 0);

        // Talk while busy
        load_ramp();
        run_burst("talkerr", 2, 1'b0, '0, 3, 0, '0, 0);

        // WLAT=1, back-to-back bursts
        run_burst("wl1_a", 1, 1'b0, '0, 0, 0, '0, 0);
        bwrite(7, 16'hA5A7, 2'b01);
        run_burst("wl1_b", 1, 1'b0, '0, 0, 0, '0, 0);
        run_burst("wl1_c", 1, 1'b1, 16'h0F0F, 0, 0, '0, 0);

        // Reset in cycle 4, then a normal burst afterwards
        run_burst("abort", 2, 1'b0, '0, 0, 0, '0, 4);
        @(posedge clk);
        #1;
        check_obs("post-reset idle", a_obs, '0);
        for (int i = 0; i < 8; i++) begin
            bwrite(i, 16'h2000 + 16'(i * 3), 2'(i));
        end
        run_burst("after_rst", 2, 1'b0, '0, 0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
